// File: rtl/pc_stack.sv
// Program counter with an integrated return-address stack for the fetch path.
// Supports jump, increment, call/return, stack status flags and sticky error reporting.
module pc_stack #(
    parameter int               WIDTH       = 16,
    parameter int               DEPTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in,
    input  logic                     load,
    input  logic                     inc,
    input  logic                     call,
    input  logic                     ret,
    input  logic                     clear_err,
    output logic [WIDTH-1:0]         out,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } stk_state_t;

    stk_state_t       state_r, state_n;
    logic [WIDTH-1:0] out_r, out_n;
    logic [DW-1:0]    depth_r, depth_n;
    logic             ovf_r, ovf_n;
    logic             unf_r, unf_n;
    logic             push_s;
    logic             at_empty_s;
    logic             at_full_s;
    logic [WIDTH-1:0] ret_addr_s;
    logic [AW-1:0]    wr_idx_s;
    logic [AW-1:0]    top_idx_s;
    logic [WIDTH-1:0] stack_r [DEPTH];

    // The low AW bits of depth wrap naturally because DEPTH is a power of two.
    assign wr_idx_s   = depth_r[AW-1:0];
    assign top_idx_s  = depth_r[AW-1:0] - AW'(1'b1);
    assign ret_addr_s = out_r + WIDTH'(1'b1);

    // Decode stack occupancy class from the state register.
    always_comb begin
        at_empty_s = 1'b0;
        at_full_s  = 1'b0;
        case (state_r)
            ST_EMPTY:   at_empty_s = 1'b1;
            ST_PARTIAL: at_empty_s = 1'b0;
            ST_FULL:    at_full_s  = 1'b1;
            default: begin
                at_empty_s = (depth_r == {DW{1'b0}});
                at_full_s  = (depth_r == DW'(DEPTH));
            end
        endcase
    end

    // Command priority: ret > call > load > inc > hold; new error events beat clear_err.
    always_comb begin
        out_n   = out_r;
        depth_n = depth_r;
        state_n = state_r;
        push_s  = 1'b0;
        ovf_n   = ovf_r & ~clear_err;
        unf_n   = unf_r & ~clear_err;
        if (ret) begin
            if (at_empty_s) begin
                unf_n = 1'b1;
            end else begin
                out_n   = stack_r[top_idx_s];
                depth_n = depth_r - DW'(1'b1);
                if (depth_r == DW'(1'b1)) begin
                    state_n = ST_EMPTY;
                end else begin
                    state_n = ST_PARTIAL;
                end
            end
        end else if (call) begin
            if (at_full_s) begin
                ovf_n = 1'b1;
            end else begin
                push_s  = 1'b1;
                out_n   = in;
                depth_n = depth_r + DW'(1'b1);
                if (depth_r == DW'(DEPTH - 1)) begin
                    state_n = ST_FULL;
                end else begin
                    state_n = ST_PARTIAL;
                end
            end
        end else if (load) begin
            out_n = in;
        end else if (inc) begin
            out_n = out_r + WIDTH'(1'b1);
        end else begin
            out_n = out_r;
        end
    end

    // Counter, occupancy, FSM and sticky flag registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            out_r   <= RESET_VALUE;
            depth_r <= {DW{1'b0}};
            state_r <= ST_EMPTY;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
        end else begin
            out_r   <= out_n;
            depth_r <= depth_n;
            state_r <= state_n;
            ovf_r   <= ovf_n;
            unf_r   <= unf_n;
        end
    end

    // Stack storage is left uncleared by reset; depth alone defines what is reachable.
    always_ff @(posedge clock) begin
        if (reset && push_s) begin
            stack_r[wr_idx_s] <= ret_addr_s;
        end
    end

    assign out       = out_r;
    assign depth     = depth_r;
    assign overflow  = ovf_r;
    assign underflow = unf_r;
    assign empty     = (depth_r == {DW{1'b0}});
    assign full      = (depth_r == DW'(DEPTH));

endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack (WIDTH=16, DEPTH=4): directed scenarios plus
// randomized traffic compared against a queue-based reference model.
module tb_pc_stack;

    localparam int          W  = 16;
    localparam int          D  = 4;
    localparam logic [15:0] RV = 16'h0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] din   = 16'h0000;
    logic        load  = 1'b0;
    logic        inc   = 1'b0;
    logic        call  = 1'b0;
    logic        ret   = 1'b0;
    logic        clear_err = 1'b0;
    logic [15:0] out;
    logic [2:0]  depth;
    logic        empty, full, overflow, underflow;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [15:0] m_pc = RV;
    logic [15:0] m_stack[$];
    bit          m_ovf = 1'b0;
    bit          m_unf = 1'b0;

    pc_stack #(.WIDTH(W), .DEPTH(D), .RESET_VALUE(RV)) dut (
        .clock(clock), .reset(reset), .in(din), .load(load), .inc(inc),
        .call(call), .ret(ret), .clear_err(clear_err), .out(out), .depth(depth),
        .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
    );

    always #5 clock = ~clock;

    // Drive one cycle of strobes, step the model by the same command, sample 1 time unit after the edge.
    task automatic cycle(input bit rb, input bit ld, input bit ic, input bit cl,
                         input bit rt, input bit ce, input logic [15:0] d);
        bit no, nu;
        reset = rb; load = ld; inc = ic; call = cl; ret = rt; clear_err = ce; din = d;
        @(posedge clock);
        no = 1'b0; nu = 1'b0;
        if (!rb) begin
            m_pc = RV; m_stack.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            if (rt) begin
                if (m_stack.size() == 0) nu = 1'b1;
                else m_pc = m_stack.pop_back();
            end else if (cl) begin
                if (m_stack.size() == D) no = 1'b1;
                else begin m_stack.push_back(16'((int'(m_pc) + 1) % 65536)); m_pc = d; end
            end else if (ld) begin
                m_pc = d;
            end else if (ic) begin
                m_pc = 16'((int'(m_pc) + 1) % 65536);
            end
            m_ovf = no || (m_ovf && !ce);
            m_unf = nu || (m_unf && !ce);
        end
        #1;
    endtask

    task automatic test_reset;
        cycle(0, 1, 0, 0, 0, 0, 16'h1234);
        total++; if (out !== 16'h0000) begin bad++; $display("FAIL rst_out got=%h want=%h", out, 16'h0000); end
        total++; if (depth !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL rst_stack got=%0d/%b/%b want=0/1/0", depth, empty, full); end
        total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b%b want=00", overflow, underflow); end
        cycle(1, 1, 1, 0, 0, 0, 16'h0100);
        total++; if (out !== 16'h0100) begin bad++; $display("FAIL load_over_inc got=%h want=%h", out, 16'h0100); end
        cycle(1, 0, 1, 0, 0, 0, 16'h7777);
        total++; if (out !== 16'h0101) begin bad++; $display("FAIL inc got=%h want=%h", out, 16'h0101); end
    endtask

    task automatic test_wrap;
        cycle(1, 1, 0, 0, 0, 0, 16'hFFFF);
        cycle(1, 0, 1, 0, 0, 0, 16'h0000);
        total++; if (out !== 16'h0000) begin bad++; $display("FAIL inc_wrap got=%h want=%h", out, 16'h0000); end
        cycle(1, 1, 0, 0, 0, 0, 16'hFFFF);
        cycle(1, 1, 0, 1, 0, 0, 16'h0200);
        total++; if (out !== 16'h0200 || depth !== 3'd1) begin bad++; $display("FAIL call_wrap got=%h/%0d want=0200/1", out, depth); end
        cycle(1, 0, 0, 0, 1, 0, 16'h0000);
        total++; if (out !== 16'h0000 || empty !== 1'b1) begin bad++; $display("FAIL ret_wrap got=%h/%b want=0000/1", out, empty); end
    endtask

    task automatic test_nested;
        logic [15:0] exp_ret [4];
        exp_ret[0] = 16'h0301; exp_ret[1] = 16'h0201; exp_ret[2] = 16'h0101; exp_ret[3] = 16'h0011;
        cycle(1, 1, 0, 0, 0, 0, 16'h0010);
        for (int i = 1; i <= 4; i++) cycle(1, 0, 0, 1, 0, 0, 16'(i * 256));
        total++; if (depth !== 3'd4 || full !== 1'b1 || out !== 16'h0400) begin bad++; $display("FAIL nest_full got=%0d/%b/%h want=4/1/0400", depth, full, out); end
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 0, 0, 1, 0, 16'h0000);
            total++; if (out !== exp_ret[i]) begin bad++; $display("FAIL nest_ret%0d got=%h want=%h", i, out, exp_ret[i]); end
        end
        total++; if (empty !== 1'b1 || depth !== 3'd0) begin bad++; $display("FAIL nest_empty got=%b/%0d want=1/0", empty, depth); end
    endtask

    task automatic test_overflow;
        cycle(1, 1, 0, 0, 0, 0, 16'h0010);
        for (int i = 1; i <= 4; i++) cycle(1, 0, 0, 1, 0, 0, 16'(i * 256));
        cycle(1, 0, 0, 1, 0, 0, 16'h0500);
        total++; if (out !== 16'h0400 || depth !== 3'd4 || overflow !== 1'b1) begin bad++; $display("FAIL ovf got=%h/%0d/%b want=0400/4/1", out, depth, overflow); end
        cycle(1, 0, 0, 0, 1, 0, 16'h0000);
        total++; if (out !== 16'h0301 || overflow !== 1'b1) begin bad++; $display("FAIL ovf_ret got=%h/%b want=0301/1", out, overflow); end
        cycle(1, 0, 0, 0, 0, 1, 16'h0000);
        total++; if (overflow !== 1'b0 || out !== 16'h0301) begin bad++; $display("FAIL ovf_clear got=%b/%h want=0/0301", overflow, out); end
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 1, 0, 16'h0000);
    endtask

    task automatic test_underflow_clear;
        cycle(1, 1, 0, 0, 0, 0, 16'h0ABC);
        cycle(1, 0, 0, 0, 1, 0, 16'h0000);
        total++; if (out !== 16'h0ABC || underflow !== 1'b1) begin bad++; $display("FAIL unf got=%h/%b want=0abc/1", out, underflow); end
        cycle(1, 0, 0, 0, 1, 1, 16'h0000);
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL unf_race got=%b want=1", underflow); end
        cycle(1, 0, 0, 0, 0, 1, 16'h0000);
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL unf_clear got=%b want=0", underflow); end
    endtask

    task automatic test_back_to_back;
        cycle(1, 1, 0, 0, 0, 0, 16'h0050);
        cycle(1, 0, 0, 1, 0, 0, 16'h0060);
        cycle(1, 1, 1, 1, 1, 0, 16'h0999);
        total++; if (out !== 16'h0051 || depth !== 3'd0) begin bad++; $display("FAIL ret_priority got=%h/%0d want=0051/0", out, depth); end
        cycle(1, 1, 0, 1, 0, 0, 16'h0070);
        cycle(1, 0, 0, 0, 1, 0, 16'h0000);
        total++; if (out !== 16'h0052) begin bad++; $display("FAIL call_then_ret got=%h want=%h", out, 16'h0052); end
    endtask

    task automatic test_reset_mid;
        cycle(1, 1, 0, 0, 0, 0, 16'h0010);
        for (int i = 1; i <= 3; i++) cycle(1, 0, 0, 1, 0, 0, 16'(i * 16 + 16'h0100));
        total++; if (depth !== 3'd3) begin bad++; $display("FAIL mid_depth got=%0d want=3", depth); end
        cycle(0, 0, 0, 1, 0, 1, 16'h0AAA);
        total++; if (out !== RV || depth !== 3'd0) begin bad++; $display("FAIL mid_reset got=%h/%0d want=%h/0", out, depth, RV); end
        cycle(1, 0, 0, 0, 1, 0, 16'h0000);
        total++; if (underflow !== 1'b1 || out !== RV) begin bad++; $display("FAIL mid_stale got=%b/%h want=1/%h", underflow, out, RV); end
    endtask

    task automatic test_random;
        logic [2:0] exp_d;
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 39) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                  16'($urandom));
            exp_d = 3'(m_stack.size());
            total++; if (out !== m_pc) begin bad++; $display("FAIL rnd_out n=%0d got=%h want=%h", n, out, m_pc); end
            total++; if (depth !== exp_d || empty !== (exp_d == 3'd0) || full !== (exp_d == 3'd4)) begin
                bad++; $display("FAIL rnd_depth n=%0d got=%0d/%b/%b want=%0d", n, depth, empty, full, exp_d); end
            total++; if (overflow !== m_ovf || underflow !== m_unf) begin
                bad++; $display("FAIL rnd_flags n=%0d got=%b%b want=%b%b", n, overflow, underflow, m_ovf, m_unf); end
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_nested();
        test_overflow();
        test_underflow_clear();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_stack.md
# pc_stack

Parametrised program counter with an integrated hardware return-address stack; the next-generation replacement for the fixed 16-bit counter in the CPU fetch path. It keeps the existing reset/load/increment counter behaviour and adds width and stack-depth parameters, call/return operations, stack status flags and sticky error reporting. It sits between the instruction decoder (which drives the control strobes) and the instruction ROM address input.

## Interface
- WIDTH, 16, bit width of the counter, the jump target and each stack entry (≥2).
- DEPTH, 8, number of return-address entries (power of two, ≥2).
- RESET_VALUE, 0, value loaded into `out` on reset (WIDTH bits).
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low; sampled on the rising edge of `clock`, and `reset`=0 clears the block.
- in  input  WIDTH  jump/call target.
- load  input  1  jump: `out` <= `in`.
- inc  input  1  `out` <= `out`+1.
- call  input  1  push `out`+1, then `out` <= `in`.
- ret  input  1  `out` <= top of stack, then pop.
- clear_err  input  1  clears the sticky error flags.
- out  output  WIDTH  current program counter.
- depth  output  $clog2(DEPTH)+1  number of valid stack entries (0..DEPTH).
- empty  output  1  `depth`==0.
- full  output  1  `depth`==DEPTH.
- overflow  output  1  sticky: a call was attempted while full.
- underflow  output  1  sticky: a return was attempted while empty.

## Operation
- Command priority is evaluated every rising edge: reset (0) > ret > call > load > inc > hold. Only the highest-priority asserted command acts. Lower-priority strobes are ignored with no side effects.
- reset: `out`=RESET_VALUE, `depth`=0, `overflow`=`underflow`=0. Stack storage contents are not cleared; they become unreachable.
- ret, not empty: `out` <= stack[`depth`-1], `depth` <= `depth`-1.
- ret, empty: `out` holds, `depth` holds, `underflow` <= 1.
- call, not full: stack[`depth`] <= (`out`+1) mod 2^WIDTH, `depth` <= `depth`+1, `out` <= `in`.
- call, full: the jump is not taken. `out` holds, the stack is unchanged, `overflow` <= 1.
- load: `out` <= `in`. The stack is unchanged.
- inc: `out` <= (`out`+1) mod 2^WIDTH. 2^WIDTH-1 wraps to 0 with no flag.
- hold: all state unchanged.
- Arithmetic is unsigned and truncated to WIDTH. A return address pushed from `out`=2^WIDTH-1 is 0.
- Error flags:
  - They stay set until `reset`=0 or `clear_err`=1.
  - If `clear_err` coincides with a new overflow or underflow event, the new event wins and the flag reads 1.
  - `clear_err` coinciding with reset has no additional effect.
- Stack state machine, per edge:
  - EMPTY (`depth`=0) → PARTIAL on a successful call. With DEPTH≥2 it never goes directly to FULL.
  - PARTIAL → EMPTY on ret at `depth`=1.
  - PARTIAL → FULL on call at `depth`=DEPTH-1.
  - FULL → PARTIAL on ret.
- Self-transitions otherwise, including the error cases.

## Timing
- `out`, `depth`, `overflow` and `underflow` are registered. They change only after a rising edge and reflect that edge's command.
- `empty` and `full` are combinational decodes of the `depth` register, with no additional input-to-output paths.
- Latency: one cycle from command strobes to `out`.
- The return value is available on `out` in the cycle immediately after ret, with no bubble.
- Back-to-back call/ret on consecutive cycles are fully supported. Each edge sees the state left by the previous edge.
- The stack read for ret is from the current top entry. No read-during-write hazard exists, because call and ret never act on the same edge.
- Reset takes effect on the edge where it is sampled low, regardless of other strobes or stack state. The first command is accepted on the first edge with `reset`=1.
- Reset values: `out`=RESET_VALUE, `depth`=0, `empty`=1, `full`=0, `overflow`=0, `underflow`=0.

## Test plan
Parameters for all scenarios: WIDTH=16, DEPTH=4.
- Reset then priority: reset low with load=1 and `in`=0x1234 → `out`=0x0000, `depth`=0, `empty`=1. Release reset, assert inc+load with `in`=0x0100 → `out`=0x0100; then inc → 0x0101.
- Wrap: load 0xFFFF, inc → `out`=0x0000. Then call with `in`=0x0200 from `out`=0xFFFF (after reload) → pushed entry is 0x0000, `out`=0x0200.
- Nested calls: from `out`=0x0010, call 0x0100, 0x0200, 0x0300, 0x0400 on consecutive cycles → `depth`=4, `full`=1. Then four ret → `out`=0x0301, 0x0201, 0x0101, 0x0011 and `empty`=1.
- Overflow: with `full`=1 and `out`=0x0400, call 0x0500 → `out` stays 0x0400, `depth`=4, `overflow`=1. A following ret returns 0x0301, and `overflow` stays 1 until clear_err.
- Underflow and clear race: with `empty`=1, ret → `out` unchanged, `underflow`=1. Then ret together with clear_err → `underflow` still 1. Then clear_err alone → 0.
- Reset mid-stack: `depth`=3, reset low with call=1 → `out`=RESET_VALUE, `depth`=0. Then ret → `underflow`=1 and `out` unchanged, so no stale entries are returned.
